divu_hilo: RTL and testbench

DIVU_HILO -- requirements
Module: divu_hilo

---
 rtl/divu_hilo.sv | 136 +++++++++++++
 tb/tb_divu_hilo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/divu_hilo.sv
// Unsigned restoring divider that writes the HI/LO register pair, one quotient bit per clock.
// It also handles MTHI/MTLO writes and raises the pipeline stall request for DIVU.
module divu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  // One restoring step. Because rem < divisor always holds, the shifted
  // remainder fits in WIDTH+1 bits, so the top bit of trial is the borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (trial[WIDTH]) begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = mt_data;
        if (lo_we) lo_d = mt_data;
        if (start && !flush) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH);
          quo_d   = dividend;
          rem_d   = '0;
          dvs_d   = divisor;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          quo_d = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // The result write takes priority over any MTHI/MTLO this cycle.
            hi_d    = rem_nx;
            lo_d    = quo_nx;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  // The issuing DIVU stalls in its own cycle. The stall is held low while rst is high.
  assign stall = ~rst & (busy_q | (start & (state_q == IDLE) & ~flush));

endmodule

// File: tb/tb_divu_hilo.sv
// Directed bench for divu_hilo: results, latency, ignored starts, flush, reset and MTHI/MTLO.
module tb_divu_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int fails  = 0;

  divu_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .mt_data(mt_data),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain run; 1: second start at cycle 10; 2: hi_we during RUN (cycle 5 and the final step)
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int mode, input string nm);
    int n, nbusy, ndone, done_at, stall_bad, extra;
    start = 1'b1; dividend = a; divisor = b;
    #1;
    checks++;
    if (stall !== 1'b1) begin fails++; $display("FAIL %s stall_on_issue got %b want 1", nm, stall); end
    tick();
    start = 1'b0;
    n = 1; nbusy = 0; ndone = 0; done_at = 0; stall_bad = 0;
    while (n < 100 && ndone == 0) begin
      if (busy === 1'b1) nbusy++;
      if (stall !== busy) stall_bad++;
      if (done === 1'b1) begin
        ndone++; done_at = n;
      end else begin
        if (mode == 1 && n == 10) begin
          start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        end
        if (mode == 2 && (n == 5 || n == 32)) begin
          hi_we = 1'b1; mt_data = 32'hAAAA0000;
        end
        tick();
        start = 1'b0; hi_we = 1'b0;
        n++;
      end
    end
    checks++;
    if (done_at != 33) begin fails++; $display("FAIL %s done_cycle got %0d want 33", nm, done_at); end
    checks++;
    if (nbusy != 32) begin fails++; $display("FAIL %s busy_cycles got %0d want 32", nm, nbusy); end
    checks++;
    if (stall_bad != 0) begin fails++; $display("FAIL %s stall_track got %0d bad cycles want 0", nm, stall_bad); end
    checks++;
    if (hi !== eh) begin fails++; $display("FAIL %s hi got %h want %h", nm, hi, eh); end
    checks++;
    if (lo !== el) begin fails++; $display("FAIL %s lo got %h want %h", nm, lo, el); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL %s after_done got done=%b busy=%b want 0 0", nm, done, busy);
    end
    if (mode == 1) begin
      extra = 0;
      repeat (40) begin
        tick();
        if (done === 1'b1 || busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin fails++; $display("FAIL %s second_start got %0d active cycles want 0", nm, extra); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = 32'd1; divisor = 32'd1;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; mt_data = '0;
    tick();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_hilo got hi=%h lo=%h want 0 0", hi, lo); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl got busy=%b done=%b stall=%b want 0 0 0", busy, done, stall);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_div(32'd100, 32'd7, 32'd2, 32'd14, 0, "div_100_7");
  endtask

  task automatic test_edge_operands();
    run_div(32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 0, "div_max_1");
    run_div(32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 0, "div_5_0");
    run_div(32'd7, 32'd9, 32'd7, 32'd0, 0, "div_7_9");
  endtask

  task automatic test_back_to_back();
    run_div(32'd100, 32'd7, 32'd2, 32'd14, 1, "start_ignored");
  endtask

  task automatic test_mt_write();
    hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'h11;
    tick();
    lo_we = 1'b1; hi_we = 1'b0; mt_data = 32'h22;
    tick();
    lo_we = 1'b0;
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin fails++; $display("FAIL mt_idle got hi=%h lo=%h want 11 22", hi, lo); end
  endtask

  task automatic test_flush();
    int n, seen;
    start = 1'b1; flush = 1'b1; dividend = 32'd100; divisor = 32'd7;
    #1;
    checks++;
    if (stall !== 1'b0) begin fails++; $display("FAIL flush_start_stall got %b want 0", stall); end
    tick();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL flush_start_busy got %b want 0", busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (n = 1; n < 15; n++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL flush_run got busy=%b done=%b want 0 0", busy, done);
    end
    seen = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL flush_no_done got %0d pulses want 0", seen); end
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin fails++; $display("FAIL flush_hilo got hi=%h lo=%h want 11 22", hi, lo); end
  endtask

  task automatic test_mt_in_run();
    run_div(32'd100, 32'd7, 32'd2, 32'd14, 2, "mthi_in_run");
    hi_we = 1'b1; mt_data = 32'hAAAA0000;
    tick();
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'hAAAA0000) begin fails++; $display("FAIL mthi_idle got %h want aaaa0000", hi); end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL rst_mid_hilo got hi=%h lo=%h want 0 0", hi, lo); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL rst_mid_ctrl got busy=%b done=%b stall=%b want 0 0 0", busy, done, stall);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    run_div(32'd7, 32'd2, 32'd1, 32'd3, 0, "div_7_2_after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_operands();
    test_back_to_back();
    test_mt_write();
    test_flush();
    test_mt_in_run();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
